commit_trace_fifo: RTL and testbench

- Buffers one record per committed instruction from the multi-cycle reference CPU core and hands the records to a trace/difftest consumer through a valid/ready port.
- Sits directly downstream of the context-update stage:
  - Captures PC and register write-back each time the core leaves its COMMIT state.
  - Tags each record with a sequence number.
  - Queues records so a slow consumer does not stall comparison.

---
 rtl/commit_trace_fifo.sv | 127 ++++++++++++
 tb/tb_commit_trace_fifo.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_trace_fifo.sv
//------------------------------------------------------------------------------
// Module   : commit_trace_fifo
// Brief    : Commit-record FIFO between the core's commit stage and a trace
//            consumer. Optional back-pressure enabled by COMMIT_TRACE_STALL_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module commit_trace_fifo #(
    parameter int DEPTH  = 16,
    parameter int DROP_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     commit_valid,
    input  logic [31:0]              commit_pc,
    input  logic                     commit_wen,
    input  logic [4:0]               commit_wreg,
    input  logic [31:0]              commit_wdata,
    output logic                     trace_valid,
    input  logic                     trace_ready,
    output logic [31:0]              trace_seq,
    output logic [31:0]              trace_pc,
    output logic                     trace_wen,
    output logic [4:0]               trace_wreg,
    output logic [31:0]              trace_wdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic [DROP_W-1:0]        drop_count,
    output logic                     overflow,
    output logic                     commit_stall
);

    localparam int              c_AW    = $clog2(DEPTH);
    localparam int              c_REC_W = 32 + 32 + 1 + 5 + 32;
    localparam logic [c_AW:0]   c_FULL  = (c_AW + 1)'(DEPTH);
    localparam logic [c_AW:0]   c_ONE   = (c_AW + 1)'(1);

    logic [c_REC_W-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]    r_wr_ptr;
    logic [c_AW-1:0]    r_rd_ptr;
    logic [c_AW:0]      r_count;
    logic [31:0]        r_seq;
    logic [DROP_W-1:0]  r_drop;
    logic               r_ovf;

    logic               w_pop;
    logic               w_push_ok;
    logic [c_REC_W-1:0] w_rec;
    logic [c_REC_W-1:0] w_head;

    assign trace_valid = (r_count != '0);
    assign w_pop       = trace_valid & trace_ready;
    // At full a push still fits when the head leaves in the same cycle.
    assign w_push_ok   = commit_valid & ((r_count != c_FULL) | w_pop);
    assign w_rec       = {r_seq, commit_pc, commit_wen & (commit_wreg != 5'd0),
                          commit_wreg, commit_wdata};

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= w_rec;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_seq    <= '0;
            r_drop   <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            if (w_push_ok && !w_pop) begin
                r_count <= r_count + c_ONE;
            end else if (!w_push_ok && w_pop) begin
                r_count <= r_count - c_ONE;
            end
            if (commit_valid) begin
                r_seq <= r_seq + 32'd1;
            end
            if (commit_valid && !w_push_ok) begin
                r_ovf <= 1'b1;
                if (r_drop != '1) begin
                    r_drop <= r_drop + DROP_W'(1);
                end
            end
        end
    end

    // Gating keeps fields at zero when empty (memory itself is not reset).
    assign w_head      = trace_valid ? r_mem[r_rd_ptr] : '0;
    assign trace_seq   = w_head[101:70];
    assign trace_pc    = w_head[69:38];
    assign trace_wen   = w_head[37];
    assign trace_wreg  = w_head[36:32];
    assign trace_wdata = w_head[31:0];

    assign count       = r_count;
    assign drop_count  = r_drop;
    assign overflow    = r_ovf;

`ifdef COMMIT_TRACE_STALL_EN
    localparam logic [c_AW:0] c_HIGH = (c_AW + 1)'(DEPTH - 1);
    logic r_stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall <= 1'b0;
        end else begin
            r_stall <= (r_count >= c_HIGH);
        end
    end

    assign commit_stall = r_stall;
`else
    assign commit_stall = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_commit_trace_fifo.sv
//------------------------------------------------------------------------------
// Module   : tb_commit_trace_fifo
// Brief    : Randomized + directed bench for commit_trace_fifo with a queue model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_commit_trace_fifo;

    localparam int DEPTH  = 16;
    localparam int DROP_W = 16;

    typedef struct {
        logic [31:0] seq;
        logic [31:0] pc;
        logic        wen;
        logic [4:0]  wreg;
        logic [31:0] wdata;
    } rec_t;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   commit_valid = 1'b0;
    logic [31:0]            commit_pc = '0;
    logic                   commit_wen = 1'b0;
    logic [4:0]             commit_wreg = '0;
    logic [31:0]            commit_wdata = '0;
    logic                   trace_valid;
    logic                   trace_ready = 1'b0;
    logic [31:0]            trace_seq;
    logic [31:0]            trace_pc;
    logic                   trace_wen;
    logic [4:0]             trace_wreg;
    logic [31:0]            trace_wdata;
    logic [$clog2(DEPTH):0] count;
    logic [DROP_W-1:0]      drop_count;
    logic                   overflow;
    logic                   commit_stall;

    int n_checks = 0;
    int n_errors = 0;

    rec_t        m_q[$];
    logic [31:0] m_seq;
    int          m_drop;
    logic        m_ovf;
    logic        m_stall;

    commit_trace_fifo #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
        .clk(clk), .reset(reset),
        .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_wen(commit_wen),
        .commit_wreg(commit_wreg), .commit_wdata(commit_wdata),
        .trace_valid(trace_valid), .trace_ready(trace_ready),
        .trace_seq(trace_seq), .trace_pc(trace_pc), .trace_wen(trace_wen),
        .trace_wreg(trace_wreg), .trace_wdata(trace_wdata),
        .count(count), .drop_count(drop_count), .overflow(overflow),
        .commit_stall(commit_stall)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_seq   = '0;
        m_drop  = 0;
        m_ovf   = 1'b0;
        m_stall = 1'b0;
    endtask

    // Applied right after a rising edge, using the inputs that edge sampled.
    task automatic model_clock();
        bit   pop;
        bit   accept;
        rec_t r;
`ifdef COMMIT_TRACE_STALL_EN
        m_stall = (m_q.size() >= DEPTH - 1);
`else
        m_stall = 1'b0;
`endif
        pop    = (m_q.size() != 0) && trace_ready;
        accept = commit_valid && ((m_q.size() < DEPTH) || pop);
        if (pop) void'(m_q.pop_front());
        if (accept) begin
            r.seq   = m_seq;
            r.pc    = commit_pc;
            r.wen   = commit_wen && (commit_wreg != 5'd0);
            r.wreg  = commit_wreg;
            r.wdata = commit_wdata;
            m_q.push_back(r);
        end
        if (commit_valid && !accept) begin
            m_ovf = 1'b1;
            if (m_drop < (1 << DROP_W) - 1) m_drop++;
        end
        if (commit_valid) m_seq = m_seq + 32'd1;
    endtask

    task automatic compare_all();
        check_eq("valid", 64'(trace_valid), 64'(m_q.size() != 0));
        check_eq("count", 64'(count), 64'(m_q.size()));
        check_eq("drop_count", 64'(drop_count), 64'(m_drop));
        check_eq("overflow", 64'(overflow), 64'(m_ovf));
        check_eq("stall", 64'(commit_stall), 64'(m_stall));
        if (m_q.size() != 0) begin
            check_eq("seq", 64'(trace_seq), 64'(m_q[0].seq));
            check_eq("pc", 64'(trace_pc), 64'(m_q[0].pc));
            check_eq("wen", 64'(trace_wen), 64'(m_q[0].wen));
            check_eq("wreg", 64'(trace_wreg), 64'(m_q[0].wreg));
            check_eq("wdata", 64'(trace_wdata), 64'(m_q[0].wdata));
        end
    endtask

    // Called at a falling edge: drive, clock once, compare at the next falling edge.
    task automatic step(input logic cv, input logic [31:0] pc, input logic wen,
                        input logic [4:0] wreg, input logic [31:0] wdata, input logic rdy);
        commit_valid = cv;
        commit_pc    = pc;
        commit_wen   = wen;
        commit_wreg  = wreg;
        commit_wdata = wdata;
        trace_ready  = rdy;
        @(posedge clk);
        model_clock();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, rdy);
    endtask

    task automatic commit(input logic [31:0] pc, input logic [31:0] wdata, input logic rdy);
        step(1'b1, pc, 1'b1, 5'd5, wdata, rdy);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        commit_valid = 1'b0;
        trace_ready  = 1'b0;
        @(negedge clk);
        model_reset();
        reset = 1'b0;
    endtask

    initial begin
        int drop_before;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_eq("rst_valid", 64'(trace_valid), 64'd0);
        check_eq("rst_count", 64'(count), 64'd0);
        check_eq("rst_fields", {trace_seq, trace_pc} | 64'(trace_wdata), 64'd0);
        check_eq("rst_drop", 64'(drop_count), 64'd0);

        // Three commits consumed as they appear
        for (int i = 0; i < 3; i++) begin
            commit(32'h8000_0000 + 32'(4 * i), 32'(i + 1), 1'b1);
            check_eq("t1_seq", 64'(trace_seq), 64'(i));
        end
        idle(1'b1);
        check_eq("t1_count0", 64'(count), 64'd0);

        // r0 writes are not reported
        step(1'b1, 32'h8000_0100, 1'b1, 5'd0, 32'hDEAD_BEEF, 1'b0);
        check_eq("r0_wen", 64'(trace_wen), 64'd0);
        idle(1'b1);

        // Overflow by dropping
        do_reset();
        for (int i = 0; i < 18; i++) commit(32'h1000 + 32'(4 * i), 32'(i), 1'b0);
        check_eq("ovf_count", 64'(count), 64'd16);
        check_eq("ovf_drop", 64'(drop_count), 64'd2);
        check_eq("ovf_flag", 64'(overflow), 64'd1);
        for (int i = 0; i < 16; i++) begin
            check_eq("drain_seq", 64'(trace_seq), 64'(i));
            idle(1'b1);
        end
        commit(32'h2000, 32'h55, 1'b0);
        check_eq("post_drop_seq", 64'(trace_seq), 64'd18);

        // Push and pop together at full
        for (int i = 0; i < 15; i++) commit(32'h3000 + 32'(4 * i), 32'(i), 1'b0);
        check_eq("full_count", 64'(count), 64'd16);
        drop_before = int'(drop_count);
        step(1'b1, 32'hCAFE_0000, 1'b1, 5'd7, 32'h1234, 1'b1);
        check_eq("pp_count", 64'(count), 64'd16);
        check_eq("pp_nodrop", 64'(drop_count), 64'(drop_before));
        for (int i = 0; i < 15; i++) idle(1'b1);
        check_eq("pp_tail_pc", 64'(trace_pc), 64'h0000_0000_CAFE_0000);
        idle(1'b1);

`ifdef COMMIT_TRACE_STALL_EN
        // Producer honours stall
        do_reset();
        for (int i = 0; i < 40; i++) begin
            if (commit_stall) break;
            commit(32'h4000 + 32'(4 * i), 32'(i), 1'b0);
        end
        check_eq("stall_high", 64'(commit_stall), 64'd1);
        check_eq("stall_nodrop", 64'(drop_count), 64'd0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b0);
        check_eq("stall_low", 64'(commit_stall), 64'd0);
`endif

        // Asynchronous reset between edges
        do_reset();
        for (int i = 0; i < 7; i++) commit(32'h5000 + 32'(4 * i), 32'(i), 1'b0);
        check_eq("pre_rst_count", 64'(count), 64'd7);
        #2 reset = 1'b1;
        #1;
        check_eq("arst_valid", 64'(trace_valid), 64'd0);
        check_eq("arst_count", 64'(count), 64'd0);
        @(negedge clk);
        model_reset();
        reset = 1'b0;
        commit(32'h6000, 32'h77, 1'b0);
        check_eq("arst_seq0", 64'(trace_seq), 64'd0);

        // Randomized traffic with varying consumer speed
        for (int ph = 0; ph < 6; ph++) begin
            int rdy_pct;
            rdy_pct = (ph % 3 == 0) ? 20 : ((ph % 3 == 1) ? 50 : 90);
            for (int i = 0; i < 100; i++) begin
                logic cv;
                cv = ($urandom_range(0, 99) < 65);
`ifdef COMMIT_TRACE_STALL_EN
                if (commit_stall && $urandom_range(0, 9) != 0) cv = 1'b0;
`endif
                step(cv, $urandom, 1'($urandom), 5'($urandom_range(0, 31)), $urandom,
                     ($urandom_range(0, 99) < rdy_pct));
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
